// File: rtl/mem_lvt_nwmr.sv
// mem_lvt_nwmr: multi-write multi-read memory built from per-port banks and a byte-lane live value table
module mem_lvt_nwmr #(
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_WR-1:0]                write_en,
  input  logic [NUM_WR*(DATA_WIDTH/8)-1:0] byte_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]     write_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]     read_data,
  output logic                             init_busy
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int LVT_W = NUM_WR > 1 ? $clog2(NUM_WR) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [BE_WIDTH-1:0] lane_en [NUM_WR];
  logic [ADDR_WIDTH-1:0] waddr [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr [NUM_RD];
  logic [LVT_W-1:0] lvt [DEPTH][BE_WIDTH];
  logic [DATA_WIDTH-1:0] bank_rd [NUM_WR][NUM_RD];
  logic [DATA_WIDTH-1:0] rd_next [NUM_RD];
  logic sweep;
  assign sweep = state == INIT && !reset;
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      lane_en[w] = '0;
      waddr[w] = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
      wdata[w] = write_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
    if (sweep) begin
      lane_en[0] = '1;
      waddr[0] = cnt;
      wdata[0] = '0;
    end else if (!reset) begin
      for (int w = 0; w < NUM_WR; w++) begin
        lane_en[w] = write_en[w] ? byte_en[w*BE_WIDTH +: BE_WIDTH] : '0;
        for (int v = 0; v < w; v++)
          if (write_en[v] && wr_addr[v*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH])
            lane_en[w] = lane_en[w] & ~byte_en[v*BE_WIDTH +: BE_WIDTH];
      end
    end
  end
  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      raddr[r] = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      rd_next[r] = '0;
      for (int b = 0; b < BE_WIDTH; b++)
        rd_next[r][8*b +: 8] = bank_rd[lvt[raddr[r]][b]][r][8*b +: 8];
    end
  end
  always_ff @(posedge clock)
    for (int w = 0; w < NUM_WR; w++)
      for (int b = 0; b < BE_WIDTH; b++)
        if (lane_en[w][b]) lvt[waddr[w]][b] <= LVT_W'(w);
  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clock)
        for (int b = 0; b < BE_WIDTH; b++)
          if (lane_en[i][b]) mem[waddr[i]][8*b +: 8] <= wdata[i][8*b +: 8];
      assign bank_rd[i][j] = mem[raddr[j]];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      init_busy <= 1'b1;
      read_data <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      read_data <= '0;
      if (&cnt) begin
        state <= READY;
        init_busy <= 1'b0;
      end
    end else begin
      for (int r = 0; r < NUM_RD; r++) read_data[r*DATA_WIDTH +: DATA_WIDTH] <= rd_next[r];
    end
  end
endmodule

// File: tb/tb_mem_lvt_nwmr.sv
// tb_mem_lvt_nwmr: table-driven scoreboard bench for the two-write two-read LVT memory
module tb_mem_lvt_nwmr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] write_en;
  logic [7:0] byte_en;
  logic [15:0] wr_addr;
  logic [63:0] write_data;
  logic [15:0] rd_addr;
  logic [63:0] read_data;
  logic init_busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  mem_lvt_nwmr dut (
    .clock(clk),
    .reset(rst),
    .write_en(write_en),
    .byte_en(byte_en),
    .wr_addr(wr_addr),
    .write_data(write_data),
    .rd_addr(rd_addr),
    .read_data(read_data),
    .init_busy(init_busy)
  );
  typedef struct {
    int due;
    int port;
    logic [31:0] exp;
    string name;
  } sb_t;
  sb_t sb[$];
  typedef struct {
    logic [1:0] we;
    logic [3:0] be0, be1;
    logic [7:0] wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [7:0] ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t v[14];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    sb_t s;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      s = sb.pop_front();
      check(s.name, read_data[s.port*32 +: 32], s.exp);
    end
  endtask
  task automatic expect_rd(int port, logic [31:0] exp, string name);
    sb.push_back('{cyc + 1, port, exp, name});
  endtask
  task automatic idle();
    write_en = '0;
    byte_en = '0;
    wr_addr = '0;
    write_data = '0;
  endtask
  task automatic wait_init(string name);
    int n = 0;
    logic [63:0] acc = '0;
    while (init_busy === 1'b1 && n < 1000) begin
      tick();
      acc |= read_data;
      n++;
    end
    check({name, "_cycles"}, 32'(n), 32'd256);
    check({name, "_rd_zero"}, acc[31:0] | acc[63:32], 32'h0);
  endtask
  initial begin
    v[0]  = '{2'b10, 4'h0, 4'hF, 8'h00, 8'h10, 32'h0, 32'hDEADBEEF, 8'h00, 8'h00, 32'h0, 32'h0};
    v[1]  = '{2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 8'h10, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF};
    v[2]  = '{2'b01, 4'hF, 4'h0, 8'h20, 8'h00, 32'h11223344, 32'h0, 8'h10, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF};
    v[3]  = '{2'b10, 4'h0, 4'h3, 8'h00, 8'h20, 32'h0, 32'hAABBCCDD, 8'h20, 8'h20, 32'h11223344, 32'h11223344};
    v[4]  = '{2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 8'h20, 8'h20, 32'h1122CCDD, 32'h1122CCDD};
    v[5]  = '{2'b11, 4'h5, 4'hF, 8'h30, 8'h30, 32'h01010101, 32'h02020202, 8'h30, 8'h30, 32'h0, 32'h0};
    v[6]  = '{2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 8'h30, 8'h30, 32'h02010201, 32'h02010201};
    v[7]  = '{2'b01, 4'hF, 4'h0, 8'h40, 8'h00, 32'h5, 32'h0, 8'h20, 8'h30, 32'h1122CCDD, 32'h02010201};
    v[8]  = '{2'b10, 4'h0, 4'hF, 8'h00, 8'h40, 32'h0, 32'h9, 8'h40, 8'h40, 32'h5, 32'h5};
    v[9]  = '{2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 8'h40, 8'h40, 32'h9, 32'h9};
    v[10] = '{2'b11, 4'h0, 4'h0, 8'h40, 8'h40, 32'hFF, 32'hFF, 8'h40, 8'h40, 32'h9, 32'h9};
    v[11] = '{2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 8'h40, 8'h10, 32'h9, 32'hDEADBEEF};
    v[12] = '{2'b11, 4'hF, 4'hF, 8'h50, 8'h51, 32'hA0A0A0A0, 32'hB0B0B0B0, 8'h00, 8'h00, 32'h0, 32'h0};
    v[13] = '{2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 32'h0, 8'h51, 8'h50, 32'hB0B0B0B0, 32'hA0A0A0A0};
    idle();
    rd_addr = '0;
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(init_busy), 32'h1);
    check("rst_rd", read_data[31:0] | read_data[63:32], 32'h0);
    rst = 1'b0;
    rd_addr = 16'hFF00;
    wait_init("init");
    expect_rd(0, 32'h0, "post_init_p0");
    expect_rd(1, 32'h0, "post_init_p1");
    tick();
    check("ready_busy", 32'(init_busy), 32'h0);
    for (int i = 0; i < 14; i++) begin
      write_en = v[i].we;
      byte_en = {v[i].be1, v[i].be0};
      wr_addr = {v[i].wa1, v[i].wa0};
      write_data = {v[i].wd1, v[i].wd0};
      rd_addr = {v[i].ra1, v[i].ra0};
      expect_rd(0, v[i].e0, $sformatf("vec%0d_p0", i));
      expect_rd(1, v[i].e1, $sformatf("vec%0d_p1", i));
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    write_en = 2'b11;
    byte_en = 8'hFF;
    wr_addr = 16'h2010;
    write_data = '1;
    rd_addr = 16'h2010;
    begin
      logic [63:0] acc = '0;
      logic busy_all = 1'b1;
      for (int i = 0; i < 100; i++) begin
        tick();
        acc |= read_data;
        busy_all &= init_busy;
      end
      check("mid_init_busy", 32'(busy_all), 32'h1);
      check("mid_init_rd_zero", acc[31:0] | acc[63:32], 32'h0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init("reinit");
    idle();
    rd_addr = 16'h2010;
    expect_rd(0, 32'h0, "after_reinit_10");
    expect_rd(1, 32'h0, "after_reinit_20");
    tick();
    rd_addr = 16'h4030;
    expect_rd(0, 32'h0, "after_reinit_30");
    expect_rd(1, 32'h0, "after_reinit_40");
    tick();
    tick();
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
